// File: rtl/mos6502_bus_responder.sv
// Bus-side partner of the 6502 core: RAM, interval timer, reset vector, RDY wait states,
// level IRQ from the timer and a synchronised, edge-detected NMI push button.
module mos6502_bus_responder #(
    parameter int          RAM_AW      = 5,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] RESET_VEC   = 16'h0200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] ADDRESS,
    input  logic        RW,
    input  logic [7:0]  DATA_OUT,
    output logic [7:0]  DATA_IN,
    output logic        RDY,
    output logic        IRQ,
    output logic        NMI,
    input  logic        NMI_BTN
);
    localparam int         RAM_DEPTH = 1 << RAM_AW;
    localparam logic [3:0] WS        = 4'(WAIT_STATES);
    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [15:0]       addr_r;
    logic              rw_r;
    logic [7:0]        ram_r [RAM_DEPTH];
    logic [7:0]        tload_r;
    logic [1:0]        ctrl_r;
    logic              pending_r;
    logic [7:0]        counter_r;
    logic              sync1_r;
    logic              sync2_r;
    logic              prev_r;

    logic [15:0]       acc_addr_s;
    logic              acc_rw_s;
    logic              commit_s;
    logic              wr_s;
    logic              ram_sel_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [7:0]        rdata_s;
    logic              expire_s;

    // Zero-wait accesses commit on the latching edge, so they decode the live bus.
    assign acc_addr_s = ZERO_WAIT ? ADDRESS : addr_r;
    assign acc_rw_s   = ZERO_WAIT ? RW : rw_r;
    assign commit_s   = (state_r == ST_IDLE) ? ZERO_WAIT : (cnt_r == 4'd1);
    assign wr_s       = commit_s & ~acc_rw_s;
    assign ram_sel_s  = ((acc_addr_s >> RAM_AW) == 16'd0);
    assign ram_idx_s  = acc_addr_s[RAM_AW-1:0];
    assign expire_s   = ctrl_r[0] & (counter_r == 8'd0);

    // Read-data mux over the address map.
    always_comb begin
        rdata_s = 8'hFF;
        if (ram_sel_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else begin
            case (acc_addr_s)
                16'hFF00: rdata_s = tload_r;
                16'hFF01: rdata_s = {6'b000000, ctrl_r};
                16'hFF02: rdata_s = {7'b0000000, pending_r};
                16'hFFFC: rdata_s = RESET_VEC[7:0];
                16'hFFFD: rdata_s = RESET_VEC[15:8];
                default:  rdata_s = 8'hFF;
            endcase
        end
    end

    // RAM array, intentionally not cleared by reset.
    always_ff @(posedge CLK) begin
        if (wr_s && ram_sel_s) begin
            ram_r[ram_idx_s] <= DATA_OUT;
        end
    end

    // Access FSM: latch in IDLE, count wait states, commit and release RDY.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 16'h0000;
            rw_r    <= 1'b1;
            DATA_IN <= 8'h00;
            RDY     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    addr_r <= ADDRESS;
                    rw_r   <= RW;
                    cnt_r  <= WS;
                    if (!ZERO_WAIT) begin
                        RDY     <= 1'b0;
                        state_r <= ST_WAIT;
                    end else begin
                        RDY <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        RDY     <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    RDY     <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
            if (commit_s && acc_rw_s) begin
                DATA_IN <= rdata_s;
            end
        end
    end

    // Timer registers; expiry beats W1C, and a TLOAD write overrides the reload.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tload_r   <= 8'h00;
            ctrl_r    <= 2'b00;
            pending_r <= 1'b0;
            counter_r <= 8'h00;
            IRQ       <= 1'b0;
        end else begin
            if (ctrl_r[0]) begin
                counter_r <= expire_s ? tload_r : (counter_r - 8'd1);
            end
            if (expire_s) begin
                pending_r <= 1'b1;
            end else if (wr_s && (acc_addr_s == 16'hFF02) && DATA_OUT[0]) begin
                pending_r <= 1'b0;
            end
            if (wr_s) begin
                case (acc_addr_s)
                    16'hFF00: begin
                        tload_r   <= DATA_OUT;
                        counter_r <= DATA_OUT;
                    end
                    16'hFF01: ctrl_r <= DATA_OUT[1:0];
                    default:  ;
                endcase
            end
            IRQ <= pending_r & ctrl_r[1];
        end
    end

    // NMI button synchroniser and rising-edge one-shot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            NMI     <= 1'b0;
        end else begin
            sync1_r <= NMI_BTN;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            NMI     <= sync2_r & ~prev_r;
        end
    end
endmodule

// File: tb/tb_mos6502_bus_responder.sv
// Bench for mos6502_bus_responder: transaction-level reference model, vector table,
// directed timer/NMI/reset sequences, random traffic, and a zero-wait instance.
module tb_mos6502_bus_responder;
    localparam int WS = 2;

    logic        CLK, RST, RW, NMI_BTN;
    logic [15:0] ADDRESS;
    logic [7:0]  DATA_OUT, DATA_IN;
    logic        RDY, IRQ, NMI;

    logic [15:0] a0;
    logic        rw0;
    logic [7:0]  do0, din0;
    logic        rdy0, irq0, nmi0;

    mos6502_bus_responder #(.RAM_AW(5), .WAIT_STATES(WS), .RESET_VEC(16'h0200)) dut (
        .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .RW(RW), .DATA_OUT(DATA_OUT),
        .DATA_IN(DATA_IN), .RDY(RDY), .IRQ(IRQ), .NMI(NMI), .NMI_BTN(NMI_BTN));

    mos6502_bus_responder #(.RAM_AW(5), .WAIT_STATES(0), .RESET_VEC(16'h0200)) dut0 (
        .CLK(CLK), .RST(RST), .ADDRESS(a0), .RW(rw0), .DATA_OUT(do0),
        .DATA_IN(din0), .RDY(rdy0), .IRQ(irq0), .NMI(nmi0), .NMI_BTN(NMI_BTN));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_ram [32];
    logic [7:0] m_tload, m_cnt, m_din;
    logic [1:0] m_ctrl;
    logic       m_pend, m_irq, m_rdy, m_nmi;
    logic       b1, b2, b3;
    int         ecount, nmi_cnt, nmi_at;

    typedef struct {
        logic        rd;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a < 16'd32) return m_ram[a[4:0]];
        case (a)
            16'hFF00: return m_tload;
            16'hFF01: return {6'b000000, m_ctrl};
            16'hFF02: return {7'b0000000, m_pend};
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'h02;
            default:  return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_tload = 8'h00; m_cnt = 8'h00; m_din = 8'h00; m_ctrl = 2'b00;
        m_pend = 1'b0; m_irq = 1'b0; m_rdy = 1'b1; m_nmi = 1'b0;
        b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
    endtask

    // One clock edge: advance the model, then compare all outputs after the edge.
    task automatic tick(input logic commit, input logic rd, input logic [15:0] a, input logic [7:0] wd);
        logic       expire;
        logic [7:0] rv;
        rv     = model_read(a);
        expire = m_ctrl[0] && (m_cnt == 8'h00);
        m_irq  = m_pend & m_ctrl[1];
        if (m_ctrl[0]) m_cnt = expire ? m_tload : m_cnt - 8'd1;
        if (expire) m_pend = 1'b1;
        if (commit && rd) m_din = rv;
        if (commit && !rd) begin
            if (a < 16'd32) m_ram[a[4:0]] = wd;
            else if (a == 16'hFF00) begin m_tload = wd; m_cnt = wd; end
            else if (a == 16'hFF01) m_ctrl = wd[1:0];
            else if (a == 16'hFF02 && wd[0] && !expire) m_pend = 1'b0;
        end
        m_nmi = b2 & ~b3;
        b3 = b2; b2 = b1; b1 = NMI_BTN;
        @(posedge CLK);
        #1;
        ecount++;
        if (NMI === 1'b1) begin nmi_cnt++; nmi_at = ecount; end
        chk("rdy", RDY, m_rdy);
        chk("data_in", DATA_IN, m_din);
        chk("irq", IRQ, m_irq);
        chk("nmi", NMI, m_nmi);
    endtask

    task automatic access(input logic rd, input logic [15:0] a, input logic [7:0] wd);
        ADDRESS = a; RW = rd; DATA_OUT = wd;
        for (int i = 0; i <= WS; i++) begin
            m_rdy = (i == WS);
            tick(i == WS, rd, a, wd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b1, 16'h8000, 8'h00);
    endtask

    initial begin
        int start;
        logic [15:0] ra;
        logic [7:0]  rw_d;
        logic        rrd;
        RST = 1'b1; NMI_BTN = 1'b0;
        ADDRESS = 16'h8000; RW = 1'b1; DATA_OUT = 8'h00;
        a0 = 16'h8000; rw0 = 1'b1; do0 = 8'h00;
        ecount = 0; nmi_cnt = 0; nmi_at = 0;
        model_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h00;

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_data_in", DATA_IN, 8'h00);
        chk("reset_rdy", RDY, 1'b1);
        chk("reset_irq", IRQ, 1'b0);
        chk("reset_nmi", NMI, 1'b0);
        chk("reset0_data_in", din0, 8'h00);
        chk("reset0_rdy", rdy0, 1'b1);
        @(negedge CLK);
        RST = 1'b0;

        // Known RAM contents
        for (int i = 0; i < 32; i++) access(1'b0, 16'(i), 8'((i * 7 + 1) & 8'hFF));

        tbl[0]  = '{1'b0, 16'h0003, 8'hA5, 8'h00};
        tbl[1]  = '{1'b1, 16'h0003, 8'h00, 8'hA5};
        tbl[2]  = '{1'b1, 16'hFFFC, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 16'hFFFD, 8'h00, 8'h02};
        tbl[4]  = '{1'b1, 16'h8000, 8'h00, 8'hFF};
        tbl[5]  = '{1'b0, 16'hFFFC, 8'h55, 8'h00};
        tbl[6]  = '{1'b1, 16'hFFFC, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 16'h0020, 8'h77, 8'h00};
        tbl[8]  = '{1'b1, 16'h0020, 8'h00, 8'hFF};
        tbl[9]  = '{1'b1, 16'h0000, 8'h00, 8'h01};
        tbl[10] = '{1'b0, 16'h001F, 8'h3C, 8'h00};
        tbl[11] = '{1'b1, 16'h001F, 8'h00, 8'h3C};
        tbl[12] = '{1'b0, 16'hFF01, 8'hFE, 8'h00};
        tbl[13] = '{1'b1, 16'hFF01, 8'h00, 8'h02};
        tbl[14] = '{1'b1, 16'hFF02, 8'h00, 8'h00};
        tbl[15] = '{1'b1, 16'hFF03, 8'h00, 8'hFF};
        for (int i = 0; i < 16; i++) begin
            access(tbl[i].rd, tbl[i].a, tbl[i].wd);
            if (tbl[i].rd) chk($sformatf("vec%0d", i), DATA_IN, tbl[i].exp);
        end
        access(1'b0, 16'hFF01, 8'h00);

        // Timer period 4, then a plain W1C with the timer stopped
        access(1'b0, 16'hFF00, 8'h03);
        access(1'b0, 16'hFF01, 8'h03);
        idle(6);
        access(1'b0, 16'hFF01, 8'h02);
        chk("irq_before_w1c", IRQ, 1'b1);
        access(1'b0, 16'hFF02, 8'h01);
        idle(1);
        chk("w1c_clears_irq", IRQ, 1'b0);

        // TLOAD=0 expires every cycle, so W1C always loses
        access(1'b0, 16'hFF00, 8'h00);
        access(1'b0, 16'hFF01, 8'h03);
        idle(1);
        access(1'b0, 16'hFF02, 8'h01);
        idle(1);
        chk("w1c_vs_expiry", IRQ, 1'b1);
        access(1'b1, 16'hFF02, 8'h00);
        chk("stat_pending", DATA_IN, 8'h01);
        access(1'b0, 16'hFF00, 8'h05);
        idle(3);
        access(1'b0, 16'hFF01, 8'h00);
        access(1'b0, 16'hFF02, 8'h01);
        idle(1);

        // NMI: held button gives a single pulse on the third edge
        nmi_cnt = 0;
        start = ecount;
        NMI_BTN = 1'b1;
        idle(4);
        NMI_BTN = 1'b0;
        idle(2);
        chk("nmi_count", nmi_cnt, 1);
        chk("nmi_delay", nmi_at - start, 3);

        // Reset in the middle of a write's wait states
        access(1'b0, 16'h0001, 8'h11);
        ADDRESS = 16'h0001; RW = 1'b0; DATA_OUT = 8'h5A;
        m_rdy = 1'b0;
        tick(1'b0, 1'b0, 16'h0001, 8'h5A);
        chk("wait_rdy_low", RDY, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_rdy", RDY, 1'b1);
        chk("rst_data_in", DATA_IN, 8'h00);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        access(1'b1, 16'h0001, 8'h00);
        chk("rst_abort_read", DATA_IN, 8'h11);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            rrd  = 1'($urandom_range(0, 1));
            rw_d = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    ra = 16'($urandom_range(0, 31));
                2: begin ra = 16'hFF00; rw_d = 8'($urandom_range(0, 6)); end
                3:       ra = 16'hFF01;
                4:       ra = 16'hFF02;
                5:       ra = 16'hFFFC;
                6:       ra = 16'hFFFD;
                7:       ra = 16'h0020;
                8:       ra = 16'hFF03;
                default: ra = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) NMI_BTN = ~NMI_BTN;
            access(rrd, ra, rw_d);
        end

        // Zero-wait instance: back-to-back accesses, data one cycle after address
        for (int i = 0; i < 4; i++) begin
            a0 = 16'(i); rw0 = 1'b0; do0 = 8'(8'h10 + i);
            @(posedge CLK);
            #1;
            chk("zw_write_rdy", rdy0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            a0 = 16'(i); rw0 = 1'b1;
            @(posedge CLK);
            #1;
            chk("zw_read_rdy", rdy0, 1'b1);
            chk($sformatf("zw_read%0d", i), din0, 8'(8'h10 + i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
